picorv_uart_bridge_soc: RTL and testbench
=========================================

Name: picorv_uart_bridge_soc

Overview:
- Simulation/synthesis top that pairs a picorv32 RISC-V core with a UART memory bridge; the core has no local memory.
- Every core memory transaction (fetch, load, store) is serialized as a request frame on tx_o; a host memory model answers on rx_i.
- Sits at chip top; the host side is a UART memory server at the same baud rate.

Parameters:
- ClkFreq, 12000000, system clock frequency in Hz.
- BaudRate, 115200, UART bit rate for both directions.
- ProgAddrReset, 32'h0000_0000, core reset PC.
- StackAddr, 32'h0000_1000, core initial stack pointer.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  reset, synchronous, active-high; core resetn = !reset_i.
- rx_i  in  1  UART receive, 8N1, idle high; carries host responses.
- tx_o  out  1  UART transmit, 8N1, idle high; carries core requests.

Behaviour:
- Bit period: Div = ClkFreq/BaudRate, integer-truncated (104 at defaults).
- UART framing: 8N1, LSB first, one start bit (0), one stop bit (1).
- Reset state:
  - tx_o = 1; all FSMs idle; bit counters cleared.
  - Core held in reset; mem_ready = 0; mem_rdata = 0.
- TX path:
  - Byte accepted only when the transmitter is idle.
  - A frame lasts 10*Div cycles; the next byte's start bit may follow the stop bit immediately.
- RX path:
  - rx_i passes through a 2-flop synchronizer.
  - Falling edge in idle triggers a start check at Div/2; if the line is high there, it is a glitch and RX returns to idle.
  - Data bits are sampled every Div cycles thereafter; stop is sampled at mid-bit.
  - Stop = 0 is a framing error: byte dropped, RX returns to idle, bridge keeps waiting.
- Request frame, sent when mem_valid rises while the bridge is idle:
  - Byte0 cmd: bit7 = write (|mem_wstrb), bit6 = mem_instr, bits5:4 = 0, bits3:0 = mem_wstrb.
  - Bytes1-4: mem_addr, little-endian.
  - Bytes5-8, writes only: mem_wdata, little-endian.
  - A read request is therefore 5 bytes; a write request is 9 bytes.
- Response frame:
  - Read: 4 bytes, assembled little-endian into mem_rdata.
  - Write: 1 ack byte, any value accepted.
- Bridge FSM:
  - IDLE -> SEND_CMD -> SEND_ADDR(4) -> [SEND_DATA(4) if write] -> WAIT_RESP(4 or 1) -> DONE -> IDLE.
  - DONE pulses mem_ready for exactly 1 cycle, with mem_rdata valid for reads.
  - Address, wdata, and wstrb are latched at the IDLE->SEND_CMD transition.
- No timeout: WAIT_RESP waits indefinitely.
- RX bytes received in any state other than WAIT_RESP are discarded.
- Byte count per response is exact; surplus bytes are discarded after DONE.
- Reset mid-transaction:
  - Aborts any frame in progress; tx_o goes high the cycle after reset is sampled.
  - Partial response data is discarded.
- The core's first fetch after reset deassertion is a read at ProgAddrReset, cmd = 0x40.

Test Plan:
- Hold reset_i for 100 cycles -> tx_o = 1 throughout; after release, first frame is 0x40,00,00,00,00 with bit time 104 clocks.
- Answer the fetch with bytes 13,05,00,00 (instr 0x00000513, li a0,0) -> mem_ready pulses once; next request has cmd 0x40 and addr 0x00000004.
- Serve program containing "sw a0,0(x0)" with a0=0x12345678 -> write frame 0x8F,00,00,00,00,78,56,34,12; send ack 0x00 -> core proceeds to the next fetch.
- Byte store sb to 0x101 -> cmd 0x82, addr bytes 01,01,00,00, wstrb = 0010.
- Inject rx_i low pulse of 20 cycles (glitch), then a byte with stop bit 0 during WAIT_RESP -> both ignored; the subsequent 4 valid bytes complete the read.
- Assert reset_i mid-way through sending addr byte 2 -> tx_o = 1 next cycle; after release, the request restarts from cmd 0x40, addr 0.

Source files
------------

// File: rtl/picorv_uart_bridge_soc.sv
// RISC-V core with no local memory; every fetch/load/store is carried over an
// 8N1 UART link as a request frame and answered by a host memory server.
module picorv32_lite #(
    parameter logic [31:0] ProgAddrReset = 32'h0000_0000,
    parameter logic [31:0] StackAddr     = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    output logic        mem_valid_o,
    output logic        mem_instr_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {C_FETCH, C_EXEC, C_MEM} cst_e;
    cst_e        cst_q;
    logic [31:0] regs_q [32];
    logic [31:0] pc_q, ir_q, alu, npc, ls_addr, wd, rs1v, rs2v;
    logic [31:0] imm_i, imm_s, imm_u, imm_j;
    logic [3:0]  strb;
    logic        wb, is_ld, is_st;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;

    assign opc   = ir_q[6:0];
    assign rd    = ir_q[11:7];
    assign f3    = ir_q[14:12];
    assign rs1v  = regs_q[ir_q[19:15]];
    assign rs2v  = regs_q[ir_q[24:20]];
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_u = {ir_q[31:12], 12'h000};
    assign imm_j = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign is_ld = (opc == 7'b0000011);
    assign is_st = (opc == 7'b0100011);

    // Small RV32I subset: LUI, AUIPC, JAL, OP-IMM (add/xor/or/and), loads, stores
    always_comb begin
        alu     = rs1v + imm_i;
        wb      = 1'b0;
        npc     = pc_q + 32'd4;
        ls_addr = rs1v + (is_st ? imm_s : imm_i);
        case (opc)
            7'b0110111: begin alu = imm_u; wb = 1'b1; end
            7'b0010111: begin alu = pc_q + imm_u; wb = 1'b1; end
            7'b1101111: begin alu = pc_q + 32'd4; wb = 1'b1; npc = pc_q + imm_j; end
            7'b0010011: begin
                wb = 1'b1;
                case (f3)
                    3'b100:  alu = rs1v ^ imm_i;
                    3'b110:  alu = rs1v | imm_i;
                    3'b111:  alu = rs1v & imm_i;
                    default: alu = rs1v + imm_i;
                endcase
            end
            default: ;
        endcase
        case (f3[1:0])
            2'b00:   begin strb = 4'b0001 << ls_addr[1:0];         wd = {4{rs2v[7:0]}};  end
            2'b01:   begin strb = 4'b0011 << {ls_addr[1], 1'b0};   wd = {2{rs2v[15:0]}}; end
            default: begin strb = 4'b1111;                         wd = rs2v;            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cst_q       <= C_FETCH;
            pc_q        <= ProgAddrReset;
            ir_q        <= '0;
            mem_valid_o <= 1'b0;
            mem_instr_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= (i == 2) ? StackAddr : 32'h0;
        end else begin
            case (cst_q)
                C_FETCH: if (!mem_valid_o) begin
                    mem_valid_o <= 1'b1;
                    mem_instr_o <= 1'b1;
                    mem_addr_o  <= pc_q;
                    mem_wstrb_o <= '0;
                end else if (mem_ready_i) begin
                    mem_valid_o <= 1'b0;
                    ir_q        <= mem_rdata_i;
                    cst_q       <= C_EXEC;
                end
                C_EXEC: begin
                    pc_q <= npc;
                    if (is_ld || is_st) begin
                        mem_valid_o <= 1'b1;
                        mem_instr_o <= 1'b0;
                        mem_addr_o  <= ls_addr;
                        mem_wstrb_o <= is_st ? strb : 4'b0000;
                        mem_wdata_o <= wd;
                        cst_q       <= C_MEM;
                    end else begin
                        if (wb && rd != 5'd0) regs_q[rd] <= alu;
                        cst_q <= C_FETCH;
                    end
                end
                C_MEM: if (mem_ready_i) begin
                    mem_valid_o <= 1'b0;
                    if (is_ld && rd != 5'd0) regs_q[rd] <= mem_rdata_i;
                    cst_q <= C_FETCH;
                end
                default: cst_q <= C_FETCH;
            endcase
        end
    end
endmodule

module picorv_uart_bridge_soc #(
    parameter int unsigned ClkFreq       = 12000000,
    parameter int unsigned BaudRate      = 115200,
    parameter logic [31:0] ProgAddrReset = 32'h0000_0000,
    parameter logic [31:0] StackAddr     = 32'h0000_1000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic tx_o
);
    localparam int unsigned Div = ClkFreq / BaudRate;
    localparam int CW = $clog2(Div) + 1;
    localparam logic [CW-1:0] DivM1  = CW'(Div - 1);
    localparam logic [CW-1:0] HalfM1 = CW'(Div / 2 - 1);

    logic        mem_valid, mem_instr, mem_ready, tx_free;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    picorv32_lite #(.ProgAddrReset(ProgAddrReset), .StackAddr(StackAddr)) u_core (
        .clk_i(clk_i), .resetn_i(!reset_i),
        .mem_valid_o(mem_valid), .mem_instr_o(mem_instr), .mem_ready_i(mem_ready),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_rdata_i(mem_rdata)
    );

    // Transmitter: idle line is the all-ones shift register draining through bit 0
    logic          tx_busy_q, tx_go_q;
    logic [9:0]    tx_sh_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [7:0]    tx_byte_q;
    assign tx_o    = tx_sh_q[0];
    assign tx_free = !tx_busy_q && !tx_go_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_busy_q <= 1'b0;
            tx_sh_q   <= '1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
        end else if (!tx_busy_q) begin
            if (tx_go_q) begin
                tx_busy_q <= 1'b1;
                tx_sh_q   <= {1'b1, tx_byte_q, 1'b0};
                tx_cnt_q  <= '0;
                tx_bit_q  <= '0;
            end
        end else if (tx_cnt_q == DivM1) begin
            tx_cnt_q <= '0;
            tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
            if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
            else                  tx_bit_q  <= tx_bit_q + 4'd1;
        end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
        end
    end

    // Receiver: rx_s_q[1] is the synchronized line, rx_s_q[2] its previous value
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxst_e;
    rxst_e         rxst_q;
    logic [2:0]    rx_s_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q, rx_byte_q;
    logic          rx_vld_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_s_q    <= 3'b111;
            rxst_q    <= R_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_byte_q <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            rx_s_q   <= {rx_s_q[1:0], rx_i};
            rx_vld_q <= 1'b0;
            rx_cnt_q <= rx_cnt_q + CW'(1);
            case (rxst_q)
                R_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_s_q[2] && !rx_s_q[1]) rxst_q <= R_START;
                end
                R_START: if (rx_cnt_q == HalfM1) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rxst_q   <= rx_s_q[1] ? R_IDLE : R_DATA;
                end
                R_DATA: if (rx_cnt_q == DivM1) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s_q[1], rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rxst_q <= R_STOP;
                end
                R_STOP: if (rx_cnt_q == DivM1) begin
                    rxst_q    <= R_IDLE;
                    rx_vld_q  <= rx_s_q[1];
                    rx_byte_q <= rx_sh_q;
                end
                default: rxst_q <= R_IDLE;
            endcase
        end
    end

    // Bridge: request bytes leave frame_q from the bottom, cmd first
    typedef enum logic [2:0] {B_IDLE, B_CMD, B_ADDR, B_DATA, B_WAIT, B_DONE} bst_e;
    bst_e        bst_q;
    logic [1:0]  bcnt_q;
    logic        wr_q, mem_ready_q;
    logic [71:0] frame_q;
    logic [31:0] mem_rdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bst_q       <= B_IDLE;
            bcnt_q      <= '0;
            wr_q        <= 1'b0;
            frame_q     <= '0;
            tx_go_q     <= 1'b0;
            tx_byte_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            tx_go_q     <= 1'b0;
            mem_ready_q <= 1'b0;
            case (bst_q)
                B_IDLE: if (mem_valid) begin
                    frame_q <= {mem_wdata, mem_addr, |mem_wstrb, mem_instr, 2'b00, mem_wstrb};
                    wr_q    <= |mem_wstrb;
                    bcnt_q  <= '0;
                    bst_q   <= B_CMD;
                end
                B_CMD, B_ADDR, B_DATA: if (tx_free) begin
                    tx_go_q   <= 1'b1;
                    tx_byte_q <= frame_q[7:0];
                    frame_q   <= {8'h00, frame_q[71:8]};
                    bcnt_q    <= bcnt_q + 2'd1;
                    if (bst_q == B_CMD) begin
                        bst_q  <= B_ADDR;
                        bcnt_q <= '0;
                    end else if (bcnt_q == 2'd3) begin
                        bst_q  <= (bst_q == B_ADDR && wr_q) ? B_DATA : B_WAIT;
                        bcnt_q <= '0;
                    end
                end
                B_WAIT: if (rx_vld_q) begin
                    bcnt_q <= bcnt_q + 2'd1;
                    if (!wr_q) mem_rdata_q <= {rx_byte_q, mem_rdata_q[31:8]};
                    if (wr_q || bcnt_q == 2'd3) begin
                        bst_q       <= B_DONE;
                        mem_ready_q <= 1'b1;
                    end
                end
                B_DONE:  bst_q <= B_IDLE;
                default: bst_q <= B_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv_uart_bridge_soc.sv
// Directed bench: plays the host memory server and checks the request frames.
module tb_picorv_uart_bridge_soc;
    localparam int DIV = 12000000 / 115200;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic rx_i = 1'b1;
    logic tx_o;
    int   checks = 0;
    int   errors = 0;
    int   rdy_cnt = 0;

    always #5 clk = ~clk;

    picorv_uart_bridge_soc dut (.clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .tx_o(tx_o));

    always @(negedge clk) if (dut.mem_ready === 1'b1) rdy_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fall(output bit ok);
        int n;
        n = 0;
        while (tx_o !== 1'b0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_o === 1'b0);
        if (!ok) chk("tx_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_byte(output logic [7:0] b, output int rise);
        logic [9:0] s;
        bit ok;
        s = '1;
        rise = 0;
        wait_fall(ok);
        if (ok) begin
            for (int c = 1; c <= 9 * DIV + DIV / 2; c++) begin
                @(negedge clk);
                if (rise == 0 && tx_o === 1'b1) rise = c;
                if (c % DIV == DIV / 2) s[c / DIV] = tx_o;
            end
        end
        chk("framing", {30'd0, s[9], s[0]}, 32'd2);
        b = s[8:1];
    endtask

    task automatic expect_frame(input string tag, input int n, input logic [71:0] exp, output int rise0);
        logic [7:0] b;
        int r;
        rise0 = 0;
        for (int i = 0; i < n; i++) begin
            get_byte(b, r);
            if (i == 0) rise0 = r;
            chk($sformatf("%s_b%0d", tag, i), {24'd0, b}, {24'd0, exp[71 - 8 * i -: 8]});
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic stop);
        logic [9:0] f;
        f = {stop, v, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            repeat (DIV) @(negedge clk);
        end
        rx_i = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8 * i +: 8], 1'b1);
    endtask

    initial begin
        int hi, r, rd0;
        bit ok;
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_o === 1'b1) hi++;
        end
        chk("rst_tx_high", hi, 100);
        chk("rst_ready", {31'd0, dut.mem_ready}, 32'd0);
        chk("rst_rdata", dut.mem_rdata, 32'd0);
        reset_i = 1'b0;

        // 0x40 starts with six zero bits plus start: line low for 7 bit times
        expect_frame("fetch0", 5, {8'h40, 32'h0000_0000, 32'h0}, r);
        chk("bit_time", r, 7 * DIV);

        rd0 = rdy_cnt;
        send_word(32'h0000_0513);
        expect_frame("fetch4", 5, {8'h40, 32'h0400_0000, 32'h0}, r);
        chk("ready_once", rdy_cnt - rd0, 1);
        chk("rdata_li", dut.mem_rdata, 32'h0000_0513);

        send_word(32'h1234_5537);
        expect_frame("fetch8", 5, {8'h40, 32'h0800_0000, 32'h0}, r);

        rd0 = rdy_cnt;
        rx_i = 1'b0;
        repeat (20) @(negedge clk);
        rx_i = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        send_byte(8'hA5, 1'b0);
        repeat (3 * DIV) @(negedge clk);
        chk("noise_no_ready", rdy_cnt - rd0, 0);
        send_word(32'h6785_0513);
        expect_frame("fetchC", 5, {8'h40, 32'h0C00_0000, 32'h0}, r);
        chk("noise_ready", rdy_cnt - rd0, 1);
        chk("rdata_noise", dut.mem_rdata, 32'h6785_0513);

        send_word(32'h00A0_2023);
        expect_frame("sw", 9, {8'h8F, 32'h0000_0000, 32'h7856_3412}, r);
        send_byte(8'h00, 1'b1);
        expect_frame("fetch10", 5, {8'h40, 32'h1000_0000, 32'h0}, r);

        send_word(32'h10A0_00A3);
        expect_frame("sb", 9, {8'h82, 32'h0101_0000, 32'h7878_7878}, r);
        send_byte(8'h5A, 1'b1);

        expect_frame("fetch14", 3, {8'h40, 8'h14, 8'h00, 48'h0}, r);
        wait_fall(ok);
        repeat (3 * DIV) @(negedge clk);
        chk("abort_mid_low", {31'd0, tx_o}, 32'd0);
        reset_i = 1'b1;
        @(negedge clk);
        chk("abort_tx_high", {31'd0, tx_o}, 32'd1);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_o === 1'b1) hi++;
        end
        chk("abort_hold_high", hi, 20);
        chk("abort_rdata", dut.mem_rdata, 32'd0);
        reset_i = 1'b0;
        expect_frame("restart", 5, {8'h40, 32'h0000_0000, 32'h0}, r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
